// File: rtl/matrix_pkg.sv
// Shared types, dimensions and the saturating rescale used by the matrix-vector MAC.
package matrix_pkg;
    localparam int DW = 16;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam int AW = 2 * DW + $clog2(CW);

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [AW-1:0] acc_t;
    typedef sample_t [CW-1:0]     vec_t;
    typedef vec_t    [RW-1:0]     mat_t;
    typedef sample_t [RW-1:0]     res_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mvm_state_t;

    typedef struct packed {
        mvm_state_t state;
        acc_t       acc;
    } mvm_dbg_t;

    // Rescale a Q2.(2*DW-2) sum back to Q1.(DW-1); the shift floors toward -inf.
    function automatic sample_t sat_shift(input acc_t v);
        acc_t sh;
        acc_t hi;
        acc_t lo;
        sh = v >>> (DW - 1);
        hi = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = ~hi;
        if (sh > hi)
            return {1'b0, {(DW-1){1'b1}}};
        else if (sh < lo)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return sh[DW-1:0];
    endfunction
endpackage

// File: rtl/matrix_vec_mac_mac.sv
// Signed multiply-accumulate with synchronous clear and a saturated, rescaled view of the next sum.
module mac_sat_unit
    import matrix_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t a,
    input  sample_t b,
    input  logic    clr,
    input  logic    en,
    output acc_t    acc,
    output sample_t sat
);
    acc_t prod;
    acc_t acc_next;

    always_comb begin
        prod     = acc_t'(a) * acc_t'(b);
        acc_next = en ? acc + prod : acc;
    end

    // sat reflects the sum including this cycle's product, so a row can retire while clr wipes acc.
    assign sat = sat_shift(acc_next);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            acc <= '0;
        else
            acc <= acc_next;
    end
endmodule

// File: rtl/matrix_vec_mac.sv
// y = M * x, one signed MAC per cycle in row-major order, with start/done handshake.
// Handshake: start is sampled only in IDLE; done is a one-cycle pulse in the cycle vec_out changes.
module matrix_vec_mac
    import matrix_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  mat_t     mat,
    input  vec_t     vec_in,
    input  logic     start,
    output logic     busy,
    output logic     done,
    output res_t     vec_out,
    output mvm_dbg_t dbg
);
    localparam int RBW = $clog2(RW);
    localparam int CBW = $clog2(CW);
    localparam logic [RBW-1:0] R_LAST = RBW'(RW - 1);
    localparam logic [CBW-1:0] C_LAST = CBW'(CW - 1);

    mvm_state_t     state, state_nxt;
    logic [RBW-1:0] r;
    logic [CBW-1:0] c;
    mat_t           snap_m;
    vec_t           snap_x;
    res_t           out_buf;
    res_t           final_buf;
    logic           clr, en, last_col, last_row;
    acc_t           acc;
    sample_t        sat;

    mac_sat_unit u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (snap_m[r][c]),
        .b     (snap_x[c]),
        .clr   (clr),
        .en    (en),
        .acc   (acc),
        .sat   (sat)
    );

    assign last_col = (c == C_LAST);
    assign last_row = (r == R_LAST);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        en        = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = RUN;
                clr       = 1'b1;
            end
            RUN: begin
                en = 1'b1;
                if (last_col) begin
                    clr = 1'b1;
                    if (last_row) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The last row retires on the same edge that publishes the vector, so merge it in here.
    always_comb begin
        final_buf         = out_buf;
        final_buf[RW - 1] = sat;
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg.state = state;
    assign dbg.acc   = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            r       <= '0;
            c       <= '0;
            snap_m  <= '0;
            snap_x  <= '0;
            out_buf <= '0;
            vec_out <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    snap_m <= mat;
                    snap_x <= vec_in;
                    r      <= '0;
                    c      <= '0;
                end
                RUN: begin
                    if (last_col) begin
                        out_buf[r] <= sat;
                        c          <= '0;
                        if (last_row) begin
                            r       <= '0;
                            vec_out <= final_buf;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_vec_mac.sv
// Bench for matrix_vec_mac: directed corner cases plus random matrices against a plain-arithmetic model.
module tb_matrix_vec_mac;
    import matrix_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     start = 1'b0;
    mat_t     mat = '0;
    vec_t     vec_in = '0;
    logic     busy, done;
    res_t     vec_out;
    mvm_dbg_t dbg;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cyc = 0;
    logic [DW-1:0] exp_q[$];

    matrix_vec_mac dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mat     (mat),
        .vec_in  (vec_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .vec_out (vec_out),
        .dbg     (dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: exact dot products, floor shift, clamp
    function automatic void model_push(input mat_t m, input vec_t x);
        longint acc;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        for (int rr = 0; rr < RW; rr++) begin
            acc = 0;
            for (int cc = 0; cc < CW; cc++)
                acc += longint'($signed(m[rr][cc])) * longint'($signed(x[cc]));
            acc = acc >>> (DW - 1);
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
            exp_q.push_back(acc[DW-1:0]);
        end
    endfunction

    function automatic sample_t rand_sample();
        case ($urandom_range(0, 5))
            0:       return 16'sh7FFF;
            1:       return 16'sh8000;
            default: return sample_t'($urandom);
        endcase
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int rr = 0; rr < RW; rr++)
            for (int cc = 0; cc < CW; cc++)
                m[rr][cc] = rand_sample();
        return m;
    endfunction

    function automatic vec_t rand_vec();
        vec_t x;
        for (int cc = 0; cc < CW; cc++) x[cc] = rand_sample();
        return x;
    endfunction

    function automatic mat_t ramp_mat();
        mat_t m;
        for (int rr = 0; rr < RW; rr++)
            for (int cc = 0; cc < CW; cc++)
                m[rr][cc] = sample_t'((cc + 1) << 8);
        return m;
    endfunction

    function automatic vec_t ramp_vec();
        vec_t x;
        for (int cc = 0; cc < CW; cc++) x[cc] = sample_t'((cc + 1) << 8);
        return x;
    endfunction

    // driver: entered at cycle 1; scrambles inputs at cycle chg, raises start at cycles p1/p2
    task automatic run_cycles(input int budget, input int chg, input int p1, input int p2,
                              output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 1; k <= budget; k++) begin
            start = (k == p1) || (k == p2);
            if (k == chg) begin
                mat    = rand_mat();
                vec_in = rand_vec();
            end
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat      = k;
                done_cyc = cyc;
                break;
            end
            tick();
        end
    endtask

    // start in the current cycle, wait for done, score; leaves the bench one cycle after done
    task automatic run_op(input string name, input mat_t m, input vec_t x,
                          input int chg, input int p1, input int p2);
        int lat, bcnt;
        logic [DW-1:0] e;
        mat    = m;
        vec_in = x;
        model_push(m, x);
        start = 1'b1;
        tick();
        run_cycles(40, chg, p1, p2, lat, bcnt);
        n_vec++;
        if (lat !== RW * CW + 1) begin
            n_err++;
            $display("FAIL %s latency: got %0d, expected %0d", name, lat, RW * CW + 1);
        end
        n_vec++;
        if (bcnt !== RW * CW + 1) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, bcnt, RW * CW + 1);
        end
        for (int rr = 0; rr < RW; rr++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (vec_out[rr] !== e) begin
                n_err++;
                $display("FAIL %s vec_out[%0d]: got %h, expected %h", name, rr, vec_out[rr], e);
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || dbg.state !== IDLE) begin
            n_err++;
            $display("FAIL reset_ctrl: busy=%b done=%b state=%0d, expected 0 0 IDLE", busy, done, dbg.state);
        end
        n_vec++;
        if (vec_out !== '0 || dbg.acc !== '0) begin
            n_err++;
            $display("FAIL reset_data: vec_out=%h acc=%h, expected 0", vec_out, dbg.acc);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        mat_t m;
        vec_t x;
        m = '0;
        for (int i = 0; i < RW; i++) m[i][i] = 16'sh7FFF;
        for (int i = 0; i < CW; i++) x[i] = 16'sh4000;
        run_op("identity", m, x, 0, 0, 0);
        for (int rr = 0; rr < RW; rr++) begin
            n_vec++;
            if (vec_out[rr] !== 16'h3FFF) begin
                n_err++;
                $display("FAIL identity_hold[%0d]: got %h, expected 3fff", rr, vec_out[rr]);
            end
        end
    endtask

    task automatic test_saturation();
        mat_t m;
        vec_t x;
        for (int i = 0; i < CW; i++) x[i] = 16'sh7FFF;
        for (int rr = 0; rr < RW; rr++)
            for (int cc = 0; cc < CW; cc++) m[rr][cc] = 16'sh7FFF;
        run_op("pos_sat", m, x, 0, 0, 0);
        n_vec++;
        if (vec_out !== {RW{16'h7FFF}}) begin
            n_err++;
            $display("FAIL pos_sat_const: got %h, expected all 7fff", vec_out);
        end
        for (int rr = 0; rr < RW; rr++)
            for (int cc = 0; cc < CW; cc++) m[rr][cc] = 16'sh8000;
        run_op("neg_sat", m, x, 0, 0, 0);
        n_vec++;
        if (vec_out !== {RW{16'h8000}}) begin
            n_err++;
            $display("FAIL neg_sat_const: got %h, expected all 8000", vec_out);
        end
    endtask

    task automatic test_snapshot();
        run_op("snapshot", ramp_mat(), ramp_vec(), 5, 0, 0);
        n_vec++;
        if (vec_out !== {RW{16'h003C}}) begin
            n_err++;
            $display("FAIL snapshot_const: got %h, expected all 003c", vec_out);
        end
    endtask

    task automatic test_start_ignored();
        int extra;
        run_op("start_busy", ramp_mat(), ramp_vec(), 0, 3, 17);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) extra++;
            tick();
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL start_busy_extra: got %0d active cycles, expected 0", extra);
        end
        n_vec++;
        if (vec_out !== {RW{16'h003C}}) begin
            n_err++;
            $display("FAIL start_busy_hold: got %h, expected all 003c", vec_out);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        mat    = rand_mat();
        vec_in = rand_vec();
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 9; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_ctrl: busy=%b done=%b, expected 0 0", busy, done);
        end
        n_vec++;
        if (vec_out !== '0) begin
            n_err++;
            $display("FAIL reset_mid_vec: got %h, expected 0", vec_out);
        end
        tick();
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) seen++;
            tick();
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_mid_done: got %0d done pulses, expected 0", seen);
        end
        run_op("after_reset", rand_mat(), rand_vec(), 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int d1;
        run_op("b2b_first", rand_mat(), rand_vec(), 0, 0, 0);
        d1 = done_cyc;
        run_op("b2b_second", rand_mat(), rand_vec(), 0, 0, 0);
        n_vec++;
        if (done_cyc - d1 !== RW * CW + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d", done_cyc - d1, RW * CW + 2);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            run_op("random", rand_mat(), rand_vec(), 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_saturation();
        test_snapshot();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
